// File: rtl/uart_tx_fifo_if.sv
// Push-side interface of the UART transmit datapath: byte write strobe plus FIFO status.
interface uart_tx_fifo_if #(
    parameter int unsigned DEPTH = 8
) ();
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [7:0]    tx_data;
    logic          tx_we;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_cnt;
    logic          ovf;

    modport master (
        output tx_data, tx_we,
        input  fifo_full, fifo_empty, fifo_cnt, ovf
    );

    modport slave (
        input  tx_data, tx_we,
        output fifo_full, fifo_empty, fifo_cnt, ovf
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmit datapath: byte FIFO feeding an 8N1/8N2 serialiser with a programmable
// baud divider. Divider and stop-bit count are latched per frame when the byte is popped.
module uart_tx_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned DW    = 16
) (
    input  logic          clk,
    input  logic          rst,
    uart_tx_fifo_if.slave push_if,
    input  logic [DW-1:0] comp_i,
    input  logic          stop_2_i,
    input  logic          tr_en_i,
    output logic          busy_o,
    output logic          tx_done_o,
    output logic          uart_tx_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    state_e        state_q, state_d;
    logic [DW-1:0] baud_q, baud_d;
    logic [DW-1:0] comp_q, comp_d;
    logic          stop2_q, stop2_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          uart_tx_q, uart_tx_d;

    logic full, empty, push, pop, bit_end, start_ok;

    // Full is taken from registered occupancy, so a pop in the same cycle does not make room.
    assign full  = (cnt_q == CW'(DEPTH));
    assign empty = (cnt_q == '0);
    assign push  = push_if.tx_we & ~full;

    assign push_if.fifo_full  = full;
    assign push_if.fifo_empty = empty;
    assign push_if.fifo_cnt   = cnt_q;
    assign push_if.ovf        = push_if.tx_we & full;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_if.tx_data;
    end

    assign bit_end  = (baud_q == comp_q);
    assign start_ok = tr_en_i & ~empty;

    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        comp_d    = comp_q;
        stop2_d   = stop2_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        pop       = 1'b0;
        tx_done_o = 1'b0;
        unique case (state_q)
            StIdle: begin
                baud_d = '0;
                if (start_ok) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    comp_d  = comp_i;
                    stop2_d = stop_2_i;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (bit_end) begin
                    baud_d    = '0;
                    bit_idx_d = '0;
                    state_d   = StData;
                end else begin
                    baud_d = baud_q + DW'(1);
                end
            end
            StData: begin
                if (bit_end) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        bit_idx_d = '0;
                        state_d   = StStop;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + DW'(1);
                end
            end
            StStop: begin
                if (bit_end) begin
                    baud_d = '0;
                    // bit_idx counts stop bits here; the last one ends the frame
                    if (bit_idx_q == {2'b00, stop2_q}) begin
                        tx_done_o = 1'b1;
                        bit_idx_d = '0;
                        if (start_ok) begin
                            pop     = 1'b1;
                            shift_d = mem_q[rd_ptr_q];
                            comp_d  = comp_i;
                            stop2_d = stop_2_i;
                            state_d = StStart;
                        end else begin
                            state_d = StIdle;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + DW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Line level follows the next state so the registered output lines up with it.
    always_comb begin
        unique case (state_d)
            StStart: uart_tx_d = 1'b0;
            StData:  uart_tx_d = shift_d[0];
            default: uart_tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            state_q   <= StIdle;
            baud_q    <= '0;
            comp_q    <= '0;
            stop2_q   <= 1'b0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            uart_tx_q <= 1'b1;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            state_q   <= state_d;
            baud_q    <= baud_d;
            comp_q    <= comp_d;
            stop2_q   <= stop2_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            uart_tx_q <= uart_tx_d;
        end
    end

    assign busy_o    = (state_q != StIdle);
    assign uart_tx_o = uart_tx_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a byte queue plus a per-frame expected line waveform predict
// every output every cycle; directed scenarios are followed by a random phase.
module tb_uart_tx_fifo;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned DW    = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] comp;
    logic          stop_2;
    logic          tr_en;
    logic          busy;
    logic          tx_done;
    logic          uart_tx;

    uart_tx_fifo_if #(.DEPTH(DEPTH)) push_if ();

    uart_tx_fifo #(.DEPTH(DEPTH), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .push_if   (push_if),
        .comp_i    (comp),
        .stop_2_i  (stop_2),
        .tr_en_i   (tr_en),
        .busy_o    (busy),
        .tx_done_o (tx_done),
        .uart_tx_o (uart_tx)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    byte unsigned m_q[$];    // bytes held in the FIFO
    bit           m_wave[$]; // line level for each remaining cycle of the frame in flight

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Inputs are set by the caller; outputs are compared mid-cycle, then the model advances.
    task automatic step();
        bit           exp_line, do_pop, do_push, rst_c, stop2_c;
        byte unsigned data_c, b;
        int unsigned  c;
        @(negedge clk);
        exp_line = (m_wave.size() > 0) ? m_wave[0] : 1'b1;
        check_eq("uart_tx", uart_tx, exp_line);
        check_eq("busy", busy, m_wave.size() > 0);
        check_eq("tx_done", tx_done, m_wave.size() == 1);
        check_eq("ovf", push_if.ovf, push_if.tx_we && (m_q.size() == DEPTH));
        check_eq("fifo_cnt", push_if.fifo_cnt, m_q.size());
        check_eq("fifo_empty", push_if.fifo_empty, m_q.size() == 0);
        check_eq("fifo_full", push_if.fifo_full, m_q.size() == DEPTH);
        do_pop  = tr_en && (m_q.size() > 0) && (m_wave.size() <= 1);
        do_push = push_if.tx_we && (m_q.size() < DEPTH);
        rst_c   = rst;
        data_c  = push_if.tx_data;
        c       = int'(comp) + 1;
        stop2_c = stop_2;
        @(posedge clk);
        #1;
        if (rst_c) begin
            m_q.delete();
            m_wave.delete();
        end else begin
            if (m_wave.size() > 0) void'(m_wave.pop_front());
            if (do_pop) begin
                b = m_q.pop_front();
                repeat (c) m_wave.push_back(1'b0);
                for (int i = 0; i < 8; i++) repeat (c) m_wave.push_back(b[i]);
                repeat (stop2_c ? 2 * c : c) m_wave.push_back(1'b1);
            end
            if (do_push) m_q.push_back(data_c);
        end
    endtask

    task automatic push_byte(input byte unsigned b);
        push_if.tx_we   = 1'b1;
        push_if.tx_data = b;
        step();
        push_if.tx_we = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((m_wave.size() > 0 || (tr_en && m_q.size() > 0)) && n < budget) begin
            step();
            n++;
        end
        if (n >= budget) check_eq("idle_timeout", n, 0);
        step();
        check_eq("idle_busy", busy, 1'b0);
        check_eq("idle_line", uart_tx, 1'b1);
    endtask

    initial begin
        int n;
        rst             = 1'b1;
        push_if.tx_we   = 1'b0;
        push_if.tx_data = 8'h00;
        comp            = '0;
        stop_2          = 1'b0;
        tr_en           = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        step();
        rst = 1'b0;
        check_eq("rst_line", uart_tx, 1'b1);
        check_eq("rst_empty", push_if.fifo_empty, 1'b1);
        repeat (2) step();

        // 0x55 at comp=3, one stop bit: 40-cycle frame
        comp  = DW'(3);
        tr_en = 1'b1;
        push_byte(8'h55);
        wait_idle(200);

        // two back-to-back 11-cycle frames at comp=0 with two stop bits
        comp   = DW'(0);
        stop_2 = 1'b1;
        push_byte(8'hA3);
        push_byte(8'h0F);
        wait_idle(200);

        // overfill with transmitter disabled, then drain
        tr_en  = 1'b0;
        stop_2 = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) push_byte(8'(i));
        check_eq("full_after_fill", push_if.fifo_full, 1'b1);
        check_eq("cnt_after_fill", push_if.fifo_cnt, DEPTH);
        tr_en = 1'b1;
        wait_idle(1000);
        check_eq("drained_empty", push_if.fifo_empty, 1'b1);

        // comp change mid-frame only affects the next frame
        comp = DW'(7);
        tr_en = 1'b0;
        push_byte(8'hFF);
        push_byte(8'h5A);
        tr_en = 1'b1;
        repeat (8 * 4 + 4) step();
        comp = DW'(1);
        wait_idle(400);

        // reset during bit 5 with three bytes still queued
        tr_en = 1'b0;
        for (int i = 0; i < 4; i++) push_byte(8'hC0 + 8'(i));
        tr_en = 1'b1;
        repeat (1 + 12 + 1) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("rst_mid_busy", busy, 1'b0);
        check_eq("rst_mid_cnt", push_if.fifo_cnt, 0);
        check_eq("rst_mid_line", uart_tx, 1'b1);
        repeat (30) step();

        // hold occupancy at DEPTH-1 so pushes coincide with pops across pointer wrap
        comp = DW'(0);
        for (int i = 0; i < 80; i++) begin
            push_if.tx_data = 8'($urandom);
            push_if.tx_we   = (m_q.size() < DEPTH - 1) ||
                              ((m_q.size() == DEPTH - 1) && (m_wave.size() == 1));
            step();
        end
        push_if.tx_we = 1'b0;
        wait_idle(1000);

        // random traffic
        for (int i = 0; i < 4000; i++) begin
            push_if.tx_we   = ($urandom_range(0, 2) == 0);
            push_if.tx_data = 8'($urandom);
            if ($urandom_range(0, 63) == 0) comp = DW'($urandom_range(0, 3));
            if ($urandom_range(0, 31) == 0) stop_2 = 1'($urandom);
            tr_en = ($urandom_range(0, 15) != 0);
            rst   = ($urandom_range(0, 499) == 0);
            step();
        end
        rst           = 1'b0;
        push_if.tx_we = 1'b0;
        tr_en         = 1'b1;
        n             = 0;
        wait_idle(3000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Transmit datapath of the UART core. It consumes write-data bytes produced by the bus-side register decode through a push interface and buffers them in a small FIFO. It serialises each byte as 8N1 or 8N2 onto uart_tx at a programmable baud divider, and flags completion and overflow for the interrupt logic.

Parameters:
DEPTH, 8, FIFO depth in bytes; power of two, 2..64
DW, 16, width of baud divider input comp

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high
tx_data  input  8  byte to enqueue
tx_we  input  1  push strobe, one byte per cycle
comp  input  DW  baud divider; bit period = comp+1 clk cycles
stop_2  input  1  0: one stop bit, 1: two stop bits
tr_en  input  1  transmitter enable
fifo_full  output  1  FIFO holds DEPTH bytes
fifo_empty  output  1  FIFO holds 0 bytes
fifo_cnt  output  $clog2(DEPTH)+1  current occupancy
busy  output  1  FSM not IDLE
tx_done  output  1  one-cycle pulse at end of each frame
ovf  output  1  one-cycle pulse when a push is dropped
uart_tx  output  1  serial line, registered, idle high

Behaviour:
- Reset (sync, rst=1 sampled on clk): uart_tx=1, busy=0, tx_done=0, ovf=0, fifo_cnt=0, fifo_empty=1, fifo_full=0. FIFO pointers are cleared and the FSM goes to IDLE. Reset mid-frame aborts the frame: uart_tx is 1 from the cycle after reset is sampled, and buffered data is discarded.
- Push: tx_we=1 and !fifo_full writes tx_data at the write pointer. The write is visible in fifo_cnt next cycle.
- Push when fifo_full: byte dropped, ovf=1 for 1 cycle, FIFO unchanged. This applies even if a pop occurs in the same cycle, because full is evaluated on the registered state.
- Simultaneous push and pop with FIFO not full: both occur and fifo_cnt is unchanged.
- Pointers wrap modulo DEPTH. fifo_cnt ranges 0..DEPTH.
- FSM states: IDLE, START, DATA, STOP.
- IDLE: if tr_en && !fifo_empty, pop the head byte into the shift register, latch comp and stop_2, and go to START. Otherwise stay, with uart_tx=1.
- START: uart_tx=0 for comp+1 cycles, then go to DATA with bit index 0.
- DATA: uart_tx = shift[0], LSB first, each bit held comp+1 cycles. After bit 7 go to STOP.
- STOP: uart_tx=1 for (comp+1) or 2*(comp+1) cycles, depending on the latched stop_2.
  - On the final STOP cycle: tx_done=1.
  - If tr_en && !fifo_empty, pop the next byte and go to START (no idle gap).
  - Otherwise go to IDLE.
- Latency: the pop cycle is N; the start bit drives uart_tx from cycle N+1.
- Frame length: 10*(comp+1) or 11*(comp+1) cycles.
- comp=0 is legal and gives 1 cycle per bit.
- comp and stop_2 changes mid-frame have no effect until the next frame, because both are latched at pop.
- tr_en deassert mid-frame: the current frame completes and no further pops occur. Pushes are still accepted while tr_en=0.
- busy=1 in START, DATA and STOP. In back-to-back frames busy stays 1 continuously.
- Baud counter is DW bits, counts 0..comp_latched, and wraps to 0 on each bit boundary.

Test Plan:
- Reset, then comp=3, stop_2=0, tr_en=1, push 0x55 → uart_tx from cycle N+1 reads 0 then 1,0,1,0,1,0,1,0 then 1, each level held 4 cycles. tx_done pulses on cycle 40 after the pop, then busy=0 and uart_tx=1.
- comp=0, stop_2=1, push 0xA3 and 0x0F on consecutive cycles → two 11-cycle frames back-to-back. Bits are 1,1,0,0,0,1,0,1 then 1,1,1,1,0,0,0,0, with no idle cycles between stop and start. There are two tx_done pulses, 11 cycles apart.
- tr_en=0, push DEPTH+1 bytes 0x00..0x08 → fifo_full=1 after 8 pushes, ovf pulses once on the 9th, fifo_cnt=8. Then set tr_en=1 → 8 frames transmit 0x00..0x07 in order and fifo_empty=1 at the end.
- Mid-DATA (bit 3 of 0xFF, comp=7), change comp to 1 → the remaining bits of the frame still last 8 cycles each. The next frame uses 2-cycle bits.
- Assert rst for 1 cycle during bit 5 of a frame with 3 bytes queued → next cycle uart_tx=1, busy=0, fifo_cnt=0. No tx_done pulse, and no further frames.
- FIFO at DEPTH-1, push and pop in the same cycle (pop at end of a frame) → fifo_cnt unchanged, no ovf. Data order is preserved across pointer wrap-around.
